mem_req_ctrl: RTL and testbench

//  Multi-cycle request controller between the pipeline MEM stage and memory2c.

---
 rtl/mem_req_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_req_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request controller between the MEM stage and memory2c: holds the pipeline for a
// programmable latency, issues a single memory cycle, and returns registered load data.
module mem_req_ctrl #(
  parameter int unsigned LATENCY     = 4,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_dump,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_createdump,
  input  logic [15:0] mem_data_out
);

  // state  | meaning
  // IDLE   | waiting for a request; dump has priority over load/store
  // WAIT   | counting down the access latency
  // ACCESS | single memory2c cycle, load data captured at its end
  // DONE   | one-cycle completion pulse (with err for unaligned)
  // DUMP   | one-cycle createdump request
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE, S_DUMP} state_e;

  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      err_q   <= 1'b0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_dump) begin
          state_d = S_DUMP;
        end else if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (ALIGN_CHECK && req_addr[0]) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d = 1'b0;
            if (LATENCY == 1) begin
              state_d = S_ACCESS;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (!wr_q) rdata_d = mem_data_out;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_DUMP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with rst forces every output low for the whole reset interval, so a
  // store caught in ACCESS never reaches memory.
  logic in_access;
  assign in_access = rst & (state_q == S_ACCESS);

  assign stall = rst & (((state_q == S_IDLE) & (req_valid | req_dump)) |
                        (state_q == S_WAIT) | (state_q == S_ACCESS) |
                        (state_q == S_DUMP));
  assign done           = rst & (state_q == S_DONE);
  assign err            = done & err_q;
  assign rdata          = rdata_q;
  assign mem_enable     = in_access;
  assign mem_wr         = in_access & wr_q;
  assign mem_addr       = in_access ? addr_q  : 16'd0;
  assign mem_data_in    = in_access ? wdata_q : 16'd0;
  assign mem_createdump = rst & (state_q == S_DUMP);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a LATENCY=4 instance for the main scenarios and a
// LATENCY=1 instance for back-to-back throughput, each with its own memory model.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        r4_valid = 0, r4_wr = 0, r4_dump = 0;
  logic [15:0] r4_addr = 0, r4_wdata = 0;
  logic        s4_stall, s4_done, s4_err, m4_en, m4_wr, m4_dump;
  logic [15:0] s4_rdata, m4_addr, m4_din, m4_dout;

  logic        r1_valid = 0, r1_wr = 0, r1_dump = 0;
  logic [15:0] r1_addr = 0, r1_wdata = 0;
  logic        s1_stall, s1_done, s1_err, m1_en, m1_wr, m1_dump;
  logic [15:0] s1_rdata, m1_addr, m1_din, m1_dout;

  mem_req_ctrl #(.LATENCY(4), .ALIGN_CHECK(1'b1)) u4 (
    .clk(clk), .rst(rst), .req_valid(r4_valid), .req_wr(r4_wr), .req_addr(r4_addr),
    .req_wdata(r4_wdata), .req_dump(r4_dump), .stall(s4_stall), .done(s4_done),
    .err(s4_err), .rdata(s4_rdata), .mem_enable(m4_en), .mem_wr(m4_wr),
    .mem_addr(m4_addr), .mem_data_in(m4_din), .mem_createdump(m4_dump),
    .mem_data_out(m4_dout));

  mem_req_ctrl #(.LATENCY(1), .ALIGN_CHECK(1'b1)) u1 (
    .clk(clk), .rst(rst), .req_valid(r1_valid), .req_wr(r1_wr), .req_addr(r1_addr),
    .req_wdata(r1_wdata), .req_dump(r1_dump), .stall(s1_stall), .done(s1_done),
    .err(s1_err), .rdata(s1_rdata), .mem_enable(m1_en), .mem_wr(m1_wr),
    .mem_addr(m1_addr), .mem_data_in(m1_din), .mem_createdump(m1_dump),
    .mem_data_out(m1_dout));

  // Word-addressed memory models with combinational read; preload port for setup.
  logic [15:0] mem4 [0:127];
  logic [15:0] mem1 [0:127];
  logic        pl_en = 0;
  logic [6:0]  pl_a = 0;
  logic [15:0] pl_d = 0;

  assign m4_dout = mem4[m4_addr[7:1]];
  assign m1_dout = mem1[m1_addr[7:1]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem4[pl_a] <= pl_d;
      mem1[pl_a] <= pl_d;
    end
    if (m4_en && m4_wr) mem4[m4_addr[7:1]] <= m4_din;
    if (m1_en && m1_wr) mem1[m1_addr[7:1]] <= m1_din;
  end

  task automatic preload(input logic [15:0] byte_addr, input logic [15:0] data);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_a = byte_addr[7:1]; pl_d = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Presents one request to u4 and records what happens over ncyc cycles.
  // Cycle 1 is the request cycle; inputs drop in the done / createdump cycle.
  task automatic run_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic dump, input int ncyc,
                         output int stall_n, output int en_n, output int wr_n,
                         output int en_c, output int done_c, output logic err_at_done,
                         output logic [15:0] rd_at_done, output int dump_n, output int dump_c);
    stall_n = 0; en_n = 0; wr_n = 0; en_c = 0; done_c = 0;
    err_at_done = 1'b0; rd_at_done = 16'h0; dump_n = 0; dump_c = 0;
    @(posedge clk); #1;
    r4_valid = 1'b1; r4_wr = wr; r4_addr = addr; r4_wdata = wdata; r4_dump = dump;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (s4_stall) stall_n++;
      if (m4_en) begin en_n++; en_c = i; end
      if (m4_wr) wr_n++;
      if (m4_dump) begin dump_n++; dump_c = i; r4_dump = 1'b0; end
      if (s4_done) begin
        done_c = i; err_at_done = s4_err; rd_at_done = s4_rdata;
        r4_valid = 1'b0;
      end
    end
    r4_valid = 1'b0; r4_dump = 1'b0;
  endtask

  int stall_n, en_n, wr_n, en_c, done_c, dump_n, dump_c;
  logic err_d;
  logic [15:0] rd;

  task automatic test_reset();
    rst = 1'b0; r4_valid = 1'b1; r4_dump = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (s4_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", s4_stall); end
    checks++; if (s4_done !== 1'b0 || s4_err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", s4_done, s4_err); end
    checks++; if (s4_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", s4_rdata); end
    checks++; if ({m4_en, m4_wr, m4_dump} !== 3'b000 || m4_addr !== 16'h0) begin errors++; $display("FAIL reset_mem: got en/wr/dump %b%b%b addr %h expected 000 0000", m4_en, m4_wr, m4_dump, m4_addr); end
    r4_valid = 1'b0; r4_dump = 1'b0;
    preload(16'h0000, 16'hABCD);
    preload(16'h0002, 16'h1111);
    preload(16'h0004, 16'h1234);
    preload(16'h0006, 16'h5A5A);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_load();
    run_req(1'b0, 16'h0000, 16'h0, 1'b0, 8, stall_n, en_n, wr_n, en_c, done_c, err_d, rd, dump_n, dump_c);
    checks++; if (stall_n !== 5) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 5", stall_n); end
    checks++; if (en_n !== 1 || en_c !== 5) begin errors++; $display("FAIL load_enable: got %0d pulses at cycle %0d expected 1 at 5", en_n, en_c); end
    checks++; if (done_c !== 6 || err_d !== 1'b0) begin errors++; $display("FAIL load_done: got cycle %0d err %b expected 6 err 0", done_c, err_d); end
    checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL load_rdata: got %h expected abcd", rd); end
  endtask

  task automatic test_store_load();
    run_req(1'b1, 16'h0004, 16'hFFFF, 1'b0, 8, stall_n, en_n, wr_n, en_c, done_c, err_d, rd, dump_n, dump_c);
    checks++; if (wr_n !== 1 || en_n !== 1) begin errors++; $display("FAIL store_wr_pulse: got wr %0d en %0d expected 1 1", wr_n, en_n); end
    checks++; if (done_c !== 6 || rd !== 16'hABCD) begin errors++; $display("FAIL store_rdata_hold: got cycle %0d rdata %h expected 6 abcd", done_c, rd); end
    run_req(1'b0, 16'h0004, 16'h0, 1'b0, 8, stall_n, en_n, wr_n, en_c, done_c, err_d, rd, dump_n, dump_c);
    checks++; if (wr_n !== 0) begin errors++; $display("FAIL load_no_wr: got %0d expected 0", wr_n); end
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL load_after_store: got %h expected ffff", rd); end
  endtask

  task automatic test_unaligned();
    run_req(1'b0, 16'h0003, 16'h0, 1'b0, 5, stall_n, en_n, wr_n, en_c, done_c, err_d, rd, dump_n, dump_c);
    checks++; if (en_n !== 0) begin errors++; $display("FAIL unaligned_no_access: got %0d enables expected 0", en_n); end
    checks++; if (done_c !== 2 || err_d !== 1'b1) begin errors++; $display("FAIL unaligned_done_err: got cycle %0d err %b expected 2 err 1", done_c, err_d); end
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL unaligned_rdata_hold: got %h expected ffff", rd); end
  endtask

  task automatic test_dump();
    run_req(1'b0, 16'h0006, 16'h0, 1'b1, 10, stall_n, en_n, wr_n, en_c, done_c, err_d, rd, dump_n, dump_c);
    checks++; if (dump_n !== 1 || dump_c !== 2) begin errors++; $display("FAIL dump_pulse: got %0d pulses at cycle %0d expected 1 at 2", dump_n, dump_c); end
    checks++; if (en_n !== 1 || en_c !== 7) begin errors++; $display("FAIL dump_then_load_enable: got %0d at cycle %0d expected 1 at 7", en_n, en_c); end
    checks++; if (done_c !== 8 || rd !== 16'h5A5A) begin errors++; $display("FAIL dump_then_load_done: got cycle %0d rdata %h expected 8 5a5a", done_c, rd); end
    checks++; if (stall_n !== 7) begin errors++; $display("FAIL dump_stall_cycles: got %0d expected 7", stall_n); end
  endtask

  task automatic test_reset_mid_access();
    int seen_en = 0;
    int seen_done = 0;
    @(posedge clk); #1;
    r4_valid = 1'b1; r4_wr = 1'b1; r4_addr = 16'h0002; r4_wdata = 16'h2222;
    for (int i = 1; i <= 8 && seen_en == 0; i++) begin
      @(negedge clk);
      if (m4_en) seen_en = i;
    end
    checks++; if (seen_en !== 5) begin errors++; $display("FAIL midrst_access_cycle: got %0d expected 5", seen_en); end
    rst = 1'b0;
    #1;
    checks++; if ({m4_en, m4_wr, s4_stall, s4_done} !== 4'b0000) begin errors++; $display("FAIL midrst_outputs: got en/wr/stall/done %b%b%b%b expected 0000", m4_en, m4_wr, s4_stall, s4_done); end
    r4_valid = 1'b0; r4_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (s4_done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", seen_done); end
    checks++; if (s4_rdata !== 16'h0) begin errors++; $display("FAIL midrst_rdata_cleared: got %h expected 0000", s4_rdata); end
    run_req(1'b0, 16'h0002, 16'h0, 1'b0, 8, stall_n, en_n, wr_n, en_c, done_c, err_d, rd, dump_n, dump_c);
    checks++; if (done_c !== 6 || rd !== 16'h1111) begin errors++; $display("FAIL midrst_store_not_committed: got cycle %0d rdata %h expected 6 1111", done_c, rd); end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int c0 = 0, c1 = 0;
    logic [15:0] d0 = 0, d1 = 0;
    @(posedge clk); #1;
    r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 16'h0000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (s1_done) begin
        if (n_done == 0) begin c0 = i; d0 = s1_rdata; r1_addr = 16'h0002; end
        else begin c1 = i; d1 = s1_rdata; r1_valid = 1'b0; end
        n_done++;
      end
    end
    r1_valid = 1'b0;
    checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
    checks++; if (c0 !== 3 || c1 !== 6) begin errors++; $display("FAIL b2b_done_spacing: got cycles %0d,%0d expected 3,6", c0, c1); end
    checks++; if (d0 !== 16'hABCD || d1 !== 16'h1111) begin errors++; $display("FAIL b2b_rdata: got %h,%h expected abcd,1111", d0, d1); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_load();
    test_unaligned();
    test_dump();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
